// File: rtl/shift_pkg.sv
// Shared operation encodings for the ms_shift_reg universal register bank.
package shift_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_JOHN = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

endpackage

// File: rtl/ms_shift_reg_if.sv
// Control/data bundle for ms_shift_reg; master drives controls, slave is the register bank.
interface ms_shift_reg_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PATTERN_W = 4
);

    logic                 En;
    logic [MODE_W-1:0]    Mode;
    logic                 Dsl;
    logic                 Dsr;
    logic [WIDTH-1:0]     Din;
    logic [PATTERN_W-1:0] Pat;
    logic [WIDTH-1:0]     Q;
    logic [WIDTH-1:0]     Qn;
    logic                 So_l;
    logic                 So_r;
    logic                 Match;

    modport master (
        output En, Mode, Dsl, Dsr, Din, Pat,
        input  Q, Qn, So_l, So_r, Match
    );

    modport slave (
        input  En, Mode, Dsl, Dsr, Din, Pat,
        output Q, Qn, So_l, So_r, Match
    );

endinterface

// File: rtl/ms_shift_reg_pat_det.sv
// Serial pattern detector fed by the shift-left input stream.
// Only compiled when SHIFT_PATTERN_DETECT_EN is defined.
`ifdef SHIFT_PATTERN_DETECT_EN
module shift_pat_det #(
    parameter int unsigned PATTERN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 shl_i,
    input  logic                 dsl_i,
    input  logic [PATTERN_W-1:0] pat_i,
    output logic                 match_o
);

    logic [PATTERN_W-1:0] hist_q, hist_d;
    logic                 match_q, match_d;

    // Shift in on enabled shift-left cycles; any other enabled mode restarts the history.
    always_comb begin
        hist_d  = hist_q;
        match_d = match_q;
        if (en_i) begin
            if (shl_i) begin
                hist_d  = {hist_q[PATTERN_W-2:0], dsl_i};
                match_d = (hist_d == pat_i);
            end else begin
                hist_d  = '0;
                match_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            match_q <= match_d;
        end
    end

    assign match_o = match_q;

endmodule
`endif

// File: rtl/ms_shift_reg.sv
// Universal WIDTH-bit shift/rotate/load/Johnson register bank.
// Optional serial pattern detector enabled by defining SHIFT_PATTERN_DETECT_EN.
module ms_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PATTERN_W = 4
) (
    input  logic          Cp,
    input  logic          Rn,
    ms_shift_reg_if.slave bus
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (bus.En) begin
            case (bus.Mode)
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], bus.Dsl};
                MODE_SHR:  q_d = {bus.Dsr, q_q[WIDTH-1:1]};
                MODE_LOAD: q_d = bus.Din;
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                // Illegal Johnson states are deliberately left to cycle uncorrected.
                MODE_JOHN: q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                MODE_CLR:  q_d = '0;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge Cp or negedge Rn) begin
        if (!Rn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.Qn   = ~q_q;
    assign bus.So_l = q_q[WIDTH-1];
    assign bus.So_r = q_q[0];

`ifdef SHIFT_PATTERN_DETECT_EN
    shift_pat_det #(
        .PATTERN_W (PATTERN_W)
    ) u_pat_det (
        .clk     (Cp),
        .rst_n   (Rn),
        .en_i    (bus.En),
        .shl_i   (bus.Mode == MODE_SHL),
        .dsl_i   (bus.Dsl),
        .pat_i   (bus.Pat),
        .match_o (bus.Match)
    );
`else
    logic unused_pat_c;
    assign unused_pat_c = ^bus.Pat;
    assign bus.Match    = 1'b0;
`endif

endmodule

// File: tb/tb_ms_shift_reg.sv
// Randomised bench for ms_shift_reg with an in-bench behavioural model and directed pins.
module tb_ms_shift_reg;
    import shift_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 4;

    logic Cp = 1'b0;
    logic Rn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    ms_shift_reg_if #(.WIDTH(W), .PATTERN_W(PW)) bus ();

    ms_shift_reg #(.WIDTH(W), .PATTERN_W(PW)) dut (
        .Cp  (Cp),
        .Rn  (Rn),
        .bus (bus.slave)
    );

    always #5 Cp = ~Cp;

    // Behavioural model: register value as an integer plus a queue of shifted-in bits.
    int unsigned mask = (1 << W) - 1;
    int unsigned m_q;
    bit          m_match;
    bit          hist[$];

    function automatic int unsigned hist_val(input bit h[$]);
        int unsigned v = 0;
        foreach (h[i]) v = (v << 1) | int'(h[i]);
        return v;
    endfunction

    always @(posedge Cp or negedge Rn) begin
        if (!Rn) begin
            m_q     <= 0;
            m_match <= 1'b0;
            hist.delete();
        end else if (bus.En) begin
            int unsigned msb;
            bit          nh[$];
            msb = (m_q >> (W - 1)) & 1;
            case (bus.Mode)
                MODE_SHL:  m_q <= ((m_q << 1) | int'(bus.Dsl)) & mask;
                MODE_SHR:  m_q <= (m_q >> 1) | (int'(bus.Dsr) << (W - 1));
                MODE_LOAD: m_q <= int'(bus.Din);
                MODE_ROL:  m_q <= ((m_q << 1) | msb) & mask;
                MODE_ROR:  m_q <= (m_q >> 1) | ((m_q & 1) << (W - 1));
                MODE_JOHN: m_q <= ((m_q << 1) | (1 - msb)) & mask;
                MODE_CLR:  m_q <= 0;
                default:   m_q <= m_q;
            endcase
`ifdef SHIFT_PATTERN_DETECT_EN
            if (bus.Mode == MODE_SHL) begin
                nh = hist;
                nh.push_back(bus.Dsl);
                if (nh.size() > PW) void'(nh.pop_front());
                hist    <= nh;
                m_match <= (hist_val(nh) == int'(bus.Pat));
            end else begin
                hist.delete();
                m_match <= 1'b0;
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge Cp) begin
        if (chk_en) begin
            chk("model_Q",     32'(bus.Q),     m_q);
            chk("model_Qn",    32'(bus.Qn),    (~m_q) & mask);
            chk("model_So_l",  32'(bus.So_l),  (m_q >> (W - 1)) & 1);
            chk("model_So_r",  32'(bus.So_r),  m_q & 1);
            chk("model_Match", 32'(bus.Match), 32'(m_match));
        end
    end

    task automatic step(input bit en, input logic [2:0] mode, input bit dsl, input bit dsr,
                        input logic [W-1:0] din);
        bus.En   = en;
        bus.Mode = mode;
        bus.Dsl  = dsl;
        bus.Dsr  = dsr;
        bus.Din  = din;
        @(posedge Cp);
        #1;
    endtask

    logic [W-1:0] john_exp [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    bit dsl_seq [7] = '{1, 0, 1, 1, 0, 1, 1};
`ifdef SHIFT_PATTERN_DETECT_EN
    bit match_exp [7] = '{0, 0, 0, 1, 0, 0, 1};
`else
    bit match_exp [7] = '{0, 0, 0, 0, 0, 0, 0};
`endif

    initial begin
        bus.En = 1'b0; bus.Mode = MODE_HOLD; bus.Dsl = 1'b0; bus.Dsr = 1'b0;
        bus.Din = '0;  bus.Pat  = 4'b1011;
        repeat (2) @(posedge Cp);
        #1 chk_en = 1'b1;

        // Reset held while loading: nothing gets through until release.
        step(1, MODE_LOAD, 0, 0, 8'hA5);
        step(1, MODE_LOAD, 0, 0, 8'hA5);
        chk("rst_Q",  32'(bus.Q),  32'h00);
        chk("rst_Qn", 32'(bus.Qn), 32'hFF);
        chk("rst_Match", 32'(bus.Match), 32'h0);
        Rn = 1'b1;
        step(1, MODE_LOAD, 0, 0, 8'hA5);
        chk("rel_Q",  32'(bus.Q),  32'hA5);
        chk("rel_Qn", 32'(bus.Qn), 32'h5A);

        // Shifts.
        step(1, MODE_LOAD, 0, 0, 8'h81);
        step(1, MODE_SHL, 1, 0, 8'h00);
        step(1, MODE_SHL, 1, 0, 8'h00);
        chk("shl_Q",    32'(bus.Q),    32'h07);
        chk("shl_So_l", 32'(bus.So_l), 32'h0);
        step(1, MODE_SHR, 0, 0, 8'h00);
        chk("shr_Q", 32'(bus.Q), 32'h03);

        // Rotates.
        step(1, MODE_LOAD, 0, 0, 8'h81);
        step(1, MODE_ROL, 0, 0, 8'h00);
        chk("rol_Q", 32'(bus.Q), 32'h03);
        step(1, MODE_ROR, 0, 0, 8'h00);
        chk("ror1_Q", 32'(bus.Q), 32'h81);
        step(1, MODE_ROR, 0, 0, 8'h00);
        chk("ror2_Q", 32'(bus.Q), 32'hC0);
        chk("ror2_So_r", 32'(bus.So_r), 32'h0);

        // Johnson full period with an En=0 hold in the middle.
        step(1, MODE_CLR, 0, 0, 8'h00);
        chk("clr_Q", 32'(bus.Q), 32'h00);
        for (int i = 0; i < 16; i++) begin
            step(1, MODE_JOHN, 0, 0, 8'h00);
            chk($sformatf("john%0d_Q", i), 32'(bus.Q), 32'(john_exp[i]));
            if (i == 7) begin
                step(0, MODE_JOHN, 0, 0, 8'h00);
                chk("john_hold_Q", 32'(bus.Q), 32'hFF);
            end
        end

        // Asynchronous reset between edges.
        step(1, MODE_LOAD, 0, 0, 8'h3C);
        chk("ld3c_Q", 32'(bus.Q), 32'h3C);
        #2 Rn = 1'b0;
        #1 chk("async_Q",  32'(bus.Q),  32'h00);
        chk("async_Qn", 32'(bus.Qn), 32'hFF);
        #1 Rn = 1'b1;
        @(posedge Cp);
        #1 chk("after_async_Q", 32'(bus.Q), 32'h3C);

        // Pattern detector stream, then a load clears Match.
        bus.Pat = 4'b1011;
        step(1, MODE_LOAD, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            step(1, MODE_SHL, dsl_seq[i], 0, 8'h00);
            chk($sformatf("pat%0d_Match", i), 32'(bus.Match), 32'(match_exp[i]));
        end
        step(1, MODE_LOAD, 0, 0, 8'h00);
        chk("pat_clr_Match", 32'(bus.Match), 32'h0);

        // Randomised traffic, biased toward shift-left so the detector fires.
        for (int i = 0; i < 3000; i++) begin
            bit          en;
            logic [2:0]  mode;
            en   = ($urandom_range(0, 7) != 0);
            mode = ($urandom_range(0, 2) == 0) ? MODE_SHL : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) bus.Pat = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                bus.En = en; bus.Mode = mode;
                #3 Rn = 1'b0;
                #2 Rn = 1'b1;
            end
            step(en, mode, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ms_shift_reg.md
Name: ms_shift_reg

Overview:
- Universal WIDTH-bit register bank built on the same edge-triggered D storage as the master-slave flip-flop stage.
- Sits directly downstream of that stage: its serial input takes the flip-flop's Q stream, and it presents parallel and complementary outputs for display and next-stage logic.
- Supports hold, shift, rotate, parallel load, Johnson count and synchronous clear, plus an optional serial pattern detector.

Parameters:
WIDTH, 8, register width in bits (min 2)
PATTERN_W, 4, detector pattern length in bits (2..WIDTH); used only with the optional feature

Ports:
Cp  input  1  clock; all state updates on rising edge
Rn  input  1  asynchronous active-low reset
En  input  1  clock enable; 0 = hold regardless of Mode
Mode  input  3  operation select (see Behaviour)
Dsl  input  1  serial input for shift-left (enters bit 0)
Dsr  input  1  serial input for shift-right (enters bit WIDTH-1)
Din  input  WIDTH  parallel load data
Q  output  WIDTH  register contents
Qn  output  WIDTH  bitwise complement of Q, combinational
So_l  output  1  Q[WIDTH-1], serial out for left shift
So_r  output  1  Q[0], serial out for right shift
Pat  input  PATTERN_W  detector pattern (optional feature only)
Match  output  1  detector hit flag (optional feature only)

Behaviour:
- Rn=0: asynchronously Q=0, Qn=all ones, So_l=0, So_r=0, Match=0, shift history=0. Asynchronous assert, release takes effect at the next Cp edge.
- Every operation has 1-cycle latency: the result is visible on Q after the rising edge.
- En=0: Q holds and the detector history holds.
- En=1, Mode:
  - 000 hold.
  - 001 shift left: Q <= {Q[W-2:0], Dsl}.
  - 010 shift right: Q <= {Dsr, Q[W-1:1]}.
  - 011 load: Q <= Din.
  - 100 rotate left: Q <= {Q[W-2:0], Q[W-1]}.
  - 101 rotate right: Q <= {Q[0], Q[W-1:1]}.
  - 110 Johnson: Q <= {Q[W-2:0], ~Q[W-1]}. Period is 2*WIDTH from any valid Johnson state.
  - 111 synchronous clear: Q <= 0.
- Mode may change every cycle. No internal FSM state beyond Q and the detector history.
- Illegal Johnson states (e.g. 0101...) are not corrected; they cycle as the formula dictates.
- Rn asserted mid-operation aborts it; the next edge after release applies the current Mode to Q=0.

Optional Feature:
Macro SHIFT_PATTERN_DETECT_EN.
- Defined:
  - A PATTERN_W-bit history register captures Dsl on every enabled cycle with Mode=001. Newest bit is in the LSB.
  - Match is registered: it is 1 in the cycle after the edge on which the history (including the new bit) equals Pat.
  - Overlapping matches are allowed, so consecutive hits assert Match on consecutive cycles.
  - Any enabled cycle with another Mode clears the history and Match at that edge.
  - A hold cycle (En=0) keeps both.
- Undefined: Pat is ignored, Match is tied 0, and no history flops exist.

Decomposition:
- Shared package shift_pkg: the Mode encoding constants MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROL, MODE_ROR, MODE_JOHN, MODE_CLR.
- One natural sub-module: shift_pat_det (history register plus comparator), instantiated only under SHIFT_PATTERN_DETECT_EN.

Test Plan:
1. Rn=0 while Mode=011 with Din=8'hA5 and Cp toggling -> Q stays 00, Qn=FF. Release Rn, next edge -> Q=A5, Qn=5A.
2. Load 8'h81, then Mode=001 with Dsl=1 for 2 edges -> Q=07, So_l=0. Then Mode=010 with Dsr=0 for 1 edge -> Q=03.
3. Load 8'h81, Mode=100 for 1 edge -> 03. Mode=101 for 2 edges -> 0x81 then 0xC0.
4. Clear, then Mode=110 for 16 edges -> sequence 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00. En=0 mid-sequence holds the value.
5. Mode=011 at 8'h3C, assert Rn asynchronously between edges -> Q=00 immediately, without waiting for a Cp edge.
6. Macro defined, Pat=4'b1011, Mode=001, Dsl stream 1,0,1,1,0,1,1 -> Match=1 after the 4th and 7th bits, 0 otherwise. A Mode=011 cycle clears Match.
